// File: rtl/cl_axil_mst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cl_axil_mst_pkg
//  Description : Shared FSM encodings, AXI response codes and the command
//                record for the cl_axil_cmd_mst AXI4-Lite initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package cl_axil_mst_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_STRB_W = c_DATA_W / 8;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_WR_REQ  = 3'd1;
    localparam state_t c_ST_WR_RESP = 3'd2;
    localparam state_t c_ST_RD_REQ  = 3'd3;
    localparam state_t c_ST_RD_RESP = 3'd4;
    localparam state_t c_ST_RSP     = 3'd5;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic                write;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
        logic [c_STRB_W-1:0] wstrb;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/cl_axil_cmd_mst_if.sv
`default_nettype none
// ============================================================================
//  Module      : cl_axil_cmd_mst_if
//  Description : Command/response stream plus AXI4-Lite master port bundle.
//                'master' is the initiator's view, 'slave' the far side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cl_axil_cmd_mst_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_wstrb;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_write;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [1:0]          rsp_resp;

    logic                m_awvalid;
    logic                m_awready;
    logic [ADDR_W-1:0]   m_awaddr;
    logic                m_wvalid;
    logic                m_wready;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_bvalid;
    logic                m_bready;
    logic [1:0]          m_bresp;
    logic                m_arvalid;
    logic                m_arready;
    logic [ADDR_W-1:0]   m_araddr;
    logic                m_rvalid;
    logic                m_rready;
    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_rresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output m_awvalid, m_awaddr, input m_awready,
        output m_wvalid, m_wdata, m_wstrb, input m_wready,
        input  m_bvalid, m_bresp, output m_bready,
        output m_arvalid, m_araddr, input m_arready,
        input  m_rvalid, m_rdata, m_rresp, output m_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  m_awvalid, m_awaddr, output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, output m_wready,
        output m_bvalid, m_bresp, input m_bready,
        input  m_arvalid, m_araddr, output m_arready,
        output m_rvalid, m_rdata, m_rresp, input m_rready
    );
endinterface
`default_nettype wire

// File: rtl/cl_axil_mst_tmo.sv
`default_nettype none
// ============================================================================
//  Module      : cl_axil_mst_tmo
//  Description : Response-wait watchdog. Counts enabled cycles since the last
//                clear and flags expiry at TIMEOUT_CYCLES-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module cl_axil_mst_tmo #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [15:0] c_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_expire = i_en && (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/cl_axil_cmd_mst.sv
`default_nettype none
// ============================================================================
//  Module      : cl_axil_cmd_mst
//  Description : Single-outstanding AXI4-Lite initiator driven by a one-beat
//                command/response stream. Optional response watchdog is
//                enabled by defining CL_AXIL_CMD_MST_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cl_axil_cmd_mst
    import cl_axil_mst_pkg::*;
#(
    parameter int ADDR_W         = c_ADDR_W,
    parameter int DATA_W         = c_DATA_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rstn,
    cl_axil_cmd_mst_if.master   bus,
    output logic                busy,
    output logic                timeout_err
);

    state_t            r_state;
    state_t            w_state_nxt;
    cmd_t              r_cmd;
    logic              r_cmd_ready;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        r_rsp_resp;

    logic w_cmd_hs;
    logic w_awvalid;
    logic w_wvalid;
    logic w_aw_done_nxt;
    logic w_w_done_nxt;
    logic w_tmo_expire;
    logic w_swallow;

    assign w_cmd_hs      = bus.cmd_valid & r_cmd_ready;
    assign w_awvalid     = (r_state == c_ST_WR_REQ) & ~r_aw_done;
    assign w_wvalid      = (r_state == c_ST_WR_REQ) & ~r_w_done;
    assign w_aw_done_nxt = r_aw_done | (w_awvalid & bus.m_awready);
    assign w_w_done_nxt  = r_w_done  | (w_wvalid  & bus.m_wready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_cmd_hs) w_state_nxt = bus.cmd_write ? c_ST_WR_REQ : c_ST_RD_REQ;
            c_ST_WR_REQ:  if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = c_ST_WR_RESP;
            c_ST_WR_RESP: if (bus.m_bvalid || w_tmo_expire) w_state_nxt = c_ST_RSP;
            c_ST_RD_REQ:  if (bus.m_arready) w_state_nxt = c_ST_RD_RESP;
            c_ST_RD_RESP: if (bus.m_rvalid || w_tmo_expire) w_state_nxt = c_ST_RSP;
            c_ST_RSP:     if (bus.rsp_ready) w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // cmd_ready is registered so it stays low throughout reset and rises the
    // cycle after the response handshake returns the FSM to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_cmd       <= '0;
            r_cmd_ready <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= c_RESP_OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == c_ST_IDLE);
            if (w_cmd_hs) begin
                r_cmd     <= '{write: bus.cmd_write, addr: bus.cmd_addr,
                               wdata: bus.cmd_wdata, wstrb: bus.cmd_wstrb};
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == c_ST_WR_REQ) begin
                r_aw_done <= w_aw_done_nxt;
                r_w_done  <= w_w_done_nxt;
            end
            if ((r_state == c_ST_WR_RESP) && (w_state_nxt == c_ST_RSP)) begin
                r_rsp_write <= r_cmd.write;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= bus.m_bvalid ? bus.m_bresp : c_RESP_SLVERR;
            end
            if ((r_state == c_ST_RD_RESP) && (w_state_nxt == c_ST_RSP)) begin
                r_rsp_write <= r_cmd.write;
                r_rsp_rdata <= bus.m_rvalid ? bus.m_rdata : '0;
                r_rsp_resp  <= bus.m_rvalid ? bus.m_rresp : c_RESP_SLVERR;
            end
        end
    end

`ifdef CL_AXIL_CMD_MST_TIMEOUT_EN
    logic w_tmo_clr;
    logic w_tmo_en;
    logic r_timeout_err;

    assign w_tmo_clr = ((w_state_nxt == c_ST_WR_RESP) && (r_state != c_ST_WR_RESP)) ||
                       ((w_state_nxt == c_ST_RD_RESP) && (r_state != c_ST_RD_RESP));
    assign w_tmo_en  = ((r_state == c_ST_WR_RESP) && !bus.m_bvalid) ||
                       ((r_state == c_ST_RD_RESP) && !bus.m_rvalid);

    cl_axil_mst_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_timeout_err <= 1'b0;
        end else if (w_tmo_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    // After any timeout a stale B/R may still arrive; accept and drop it.
    assign w_swallow   = r_timeout_err && (r_state == c_ST_IDLE);
    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_expire = 1'b0;
    assign w_swallow    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.m_awvalid = w_awvalid;
    assign bus.m_awaddr  = r_cmd.addr;
    assign bus.m_wvalid  = w_wvalid;
    assign bus.m_wdata   = r_cmd.wdata;
    assign bus.m_wstrb   = r_cmd.wstrb;
    assign bus.m_bready  = (r_state == c_ST_WR_RESP) || w_swallow;
    assign bus.m_arvalid = (r_state == c_ST_RD_REQ);
    assign bus.m_araddr  = r_cmd.addr;
    assign bus.m_rready  = (r_state == c_ST_RD_RESP) || w_swallow;
    assign bus.rsp_valid = (r_state == c_ST_RSP);
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_resp  = r_rsp_resp;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cl_axil_cmd_mst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cl_axil_cmd_mst
//  Description : Self-checking bench for cl_axil_cmd_mst with a scripted
//                AXI-Lite slave and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cl_axil_cmd_mst;
    import cl_axil_mst_pkg::*;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;
    logic timeout_err;

    cl_axil_cmd_mst_if bus ();

    cl_axil_cmd_mst #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    // slave configuration (written by the test sequence only)
    int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    bit          r_never = 1'b0;
    bit          r_late_tgl = 1'b0;

    // slave observations (written by the slave process only)
    int          aw_beats = 0, w_beats = 0, ar_beats = 0;
    int          aw_vcyc = 0, w_vcyc = 0, rrdy_cyc = 0, aw_unstable = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;

    initial begin : slave
        int aw_c = 0, w_c = 0, b_c = 0, r_c = 0;
        bit aw_p = 0, w_p = 0, b_arm = 0, r_arm = 0, prev_awv = 0, late_seen = 0;
        logic [31:0] prev_awa = '0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
        bus.m_bvalid = 0; bus.m_bresp = 0;
        bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
                bus.m_bvalid = 0; bus.m_rvalid = 0;
                aw_c = 0; w_c = 0; b_c = 0; r_c = 0;
                aw_p = 0; w_p = 0; b_arm = 0; r_arm = 0; prev_awv = 0;
                late_seen = r_late_tgl;
            end else begin
                if (bus.m_awvalid) begin
                    aw_vcyc++;
                    if (prev_awv && bus.m_awaddr !== prev_awa) aw_unstable++;
                    if (aw_c >= aw_delay) begin
                        bus.m_awready = 1; aw_beats++; last_awaddr = bus.m_awaddr;
                        aw_p = 1; aw_c = 0;
                    end else begin
                        bus.m_awready = 0; aw_c++;
                    end
                end else bus.m_awready = 0;
                prev_awv = bus.m_awvalid; prev_awa = bus.m_awaddr;

                if (bus.m_wvalid) begin
                    w_vcyc++;
                    if (w_c >= w_delay) begin
                        bus.m_wready = 1; w_beats++; last_wdata = bus.m_wdata;
                        last_wstrb = bus.m_wstrb; w_p = 1; w_c = 0;
                    end else begin
                        bus.m_wready = 0; w_c++;
                    end
                end else bus.m_wready = 0;

                if (aw_p && w_p) begin b_arm = 1; aw_p = 0; w_p = 0; end

                if (bus.m_bvalid) bus.m_bvalid = 0;
                else if (b_arm && bus.m_bready) begin
                    if (b_c >= b_delay) begin
                        bus.m_bvalid = 1; bus.m_bresp = bresp_cfg; b_arm = 0; b_c = 0;
                    end else b_c++;
                end

                if (bus.m_arvalid) begin
                    bus.m_arready = 1; ar_beats++; last_araddr = bus.m_araddr; r_arm = 1;
                end else bus.m_arready = 0;

                if (late_seen != r_late_tgl) begin
                    late_seen = r_late_tgl;
                    bus.m_rvalid = 1; bus.m_rdata = 32'hBAD0_BAD0; bus.m_rresp = 2'b00;
                    r_arm = 0;
                end else if (bus.m_rvalid) bus.m_rvalid = 0;
                else if (r_arm && bus.m_rready && !r_never) begin
                    if (r_c >= r_delay) begin
                        bus.m_rvalid = 1; bus.m_rdata = rdata_cfg; bus.m_rresp = rresp_cfg;
                        r_arm = 0; r_c = 0;
                    end else r_c++;
                end
                if (bus.m_rready) rrdy_cyc++;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        int t = 0;
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = wdata; bus.cmd_wstrb = wstrb;
        while (bus.cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            n_vec++; n_err++;
            $display("FAIL cmd_accept: cmd_ready never rose (got %0b, want 1)", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 0;
    endtask

    task automatic get_rsp(output logic w, output logic [31:0] d,
                           output logic [1:0] r, output bit ok);
        int t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        ok = (bus.rsp_valid === 1'b1);
        w = bus.rsp_write; d = bus.rsp_rdata; r = bus.rsp_resp;
        if (ok) begin
            bus.rsp_ready = 1; @(negedge clk); bus.rsp_ready = 0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if ({bus.cmd_ready, busy, bus.rsp_valid, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid,
             bus.m_bready, bus.m_rready, timeout_err} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000000", {bus.cmd_ready, busy, bus.rsp_valid,
                     bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready, timeout_err});
        end
        n_vec++;
        if ({bus.rsp_write, bus.rsp_rdata, bus.rsp_resp} !== 35'b0) begin
            n_err++;
            $display("FAIL reset_rsp: got w=%b d=%h r=%b want all zero",
                     bus.rsp_write, bus.rsp_rdata, bus.rsp_resp);
        end
        rstn = 1;
        @(negedge clk);
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_basic;
        int b_aw = aw_beats, b_w = w_beats, b_awc = aw_vcyc, b_wc = w_vcyc;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        bresp_cfg = 2'b00;
        sb.push_back('{1'b1, 32'h0, 2'b00});
        send_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        n_vec++;
        if ({bus.m_awvalid, bus.m_wvalid} !== 2'b11) begin
            n_err++; $display("FAIL wr_first_valid: got aw/w=%b want 11", {bus.m_awvalid, bus.m_wvalid});
        end
        get_rsp(w, d, r, ok);
        e = sb.pop_front();
        n_vec++;
        if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
            n_err++; $display("FAIL wr_rsp: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                              ok, w, d, r, e.write, e.rdata, e.resp);
        end
        n_vec++;
        if ({aw_beats - b_aw, w_beats - b_w, aw_vcyc - b_awc, w_vcyc - b_wc} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            n_err++; $display("FAIL wr_beats: got aw=%0d w=%0d awcyc=%0d wcyc=%0d want 1 1 1 1",
                              aw_beats - b_aw, w_beats - b_w, aw_vcyc - b_awc, w_vcyc - b_wc);
        end
        n_vec++;
        if ({last_awaddr, last_wdata, last_wstrb} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
            n_err++; $display("FAIL wr_payload: got a=%h d=%h s=%h want 00001000 deadbeef f",
                              last_awaddr, last_wdata, last_wstrb);
        end
    endtask

    task automatic test_write_aw_delay;
        int b_aw = aw_beats, b_awc = aw_vcyc, b_wc = w_vcyc, b_un = aw_unstable;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        aw_delay = 5; bresp_cfg = c_RESP_SLVERR;
        sb.push_back('{1'b1, 32'h0, 2'b10});
        send_cmd(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 4'h3);
        get_rsp(w, d, r, ok);
        e = sb.pop_front();
        n_vec++;
        if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
            n_err++; $display("FAIL awdly_rsp: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                              ok, w, d, r, e.write, e.rdata, e.resp);
        end
        n_vec++;
        if ({aw_vcyc - b_awc, w_vcyc - b_wc, aw_unstable - b_un, aw_beats - b_aw} !== {32'd6, 32'd1, 32'd0, 32'd1}) begin
            n_err++; $display("FAIL awdly_timing: got awcyc=%0d wcyc=%0d unstable=%0d aw=%0d want 6 1 0 1",
                              aw_vcyc - b_awc, w_vcyc - b_wc, aw_unstable - b_un, aw_beats - b_aw);
        end
        n_vec++;
        if ({last_awaddr, last_wdata, last_wstrb} !== {32'h0000_2000, 32'h0BAD_F00D, 4'h3}) begin
            n_err++; $display("FAIL awdly_payload: got a=%h d=%h s=%h want 00002000 0badf00d 3",
                              last_awaddr, last_wdata, last_wstrb);
        end
        aw_delay = 0; bresp_cfg = c_RESP_OKAY;
    endtask

    task automatic test_read;
        int b_ar = ar_beats;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        rdata_cfg = 32'h1234_5678; rresp_cfg = c_RESP_DECERR;
        sb.push_back('{1'b0, 32'h1234_5678, 2'b11});
        send_cmd(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);
        n_vec++;
        if (bus.m_arvalid !== 1'b1) begin
            n_err++; $display("FAIL rd_first_valid: got arvalid=%b want 1", bus.m_arvalid);
        end
        get_rsp(w, d, r, ok);
        e = sb.pop_front();
        n_vec++;
        if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
            n_err++; $display("FAIL rd_rsp: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                              ok, w, d, r, e.write, e.rdata, e.resp);
        end
        n_vec++;
        if ({ar_beats - b_ar, last_araddr} !== {32'd1, 32'h0000_0004}) begin
            n_err++; $display("FAIL rd_addr: got beats=%0d a=%h want 1 00000004", ar_beats - b_ar, last_araddr);
        end
        rresp_cfg = c_RESP_OKAY;
    endtask

    task automatic test_rsp_backpressure;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        int t = 0;
        rdata_cfg = 32'hCAFE_0001;
        sb.push_back('{1'b0, 32'hCAFE_0001, 2'b00});
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        while (bus.rsp_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_rdata, bus.rsp_resp} !==
                {1'b1, 1'b0, e.write, e.rdata, e.resp}) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b cr=%b w=%b d=%h r=%b want v=1 cr=0 w=%b d=%h r=%b",
                                  i, bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_rdata, bus.rsp_resp,
                                  e.write, e.rdata, e.resp);
            end
            @(negedge clk);
        end
        get_rsp(w, d, r, ok);
        n_vec++;
        if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
            n_err++; $display("FAIL bp_rsp: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                              ok, w, d, r, e.write, e.rdata, e.resp);
        end
        n_vec++;
        if ({bus.cmd_ready, bus.rsp_valid, busy} !== 3'b100) begin
            n_err++; $display("FAIL bp_release: got cr/rv/busy=%b want 100", {bus.cmd_ready, bus.rsp_valid, busy});
        end
    endtask

    task automatic test_back_to_back;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        int b_aw = aw_beats, b_ar = ar_beats;
        b_delay = 2; r_delay = 3; rdata_cfg = 32'hA5A5_0F0F; rresp_cfg = 2'b01;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                sb.push_back('{1'b1, 32'h0, 2'b00});
                send_cmd(1'b1, 32'h100 + 32'(i * 4), 32'h5000_0000 + 32'(i), 4'(1 << i));
            end else begin
                sb.push_back('{1'b0, 32'hA5A5_0F0F, 2'b01});
                send_cmd(1'b0, 32'h200, 32'h0, 4'h0);
            end
            get_rsp(w, d, r, ok);
            e = sb.pop_front();
            n_vec++;
            if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
                n_err++; $display("FAIL b2b_rsp[%0d]: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                                  i, ok, w, d, r, e.write, e.rdata, e.resp);
            end
        end
        n_vec++;
        if ({aw_beats - b_aw, ar_beats - b_ar, last_wdata, last_wstrb} !== {32'd2, 32'd1, 32'h5000_0001, 4'h2}) begin
            n_err++; $display("FAIL b2b_beats: got aw=%0d ar=%0d d=%h s=%h want 2 1 50000001 2",
                              aw_beats - b_aw, ar_beats - b_ar, last_wdata, last_wstrb);
        end
        b_delay = 0; r_delay = 0; rresp_cfg = 2'b00;
    endtask

`ifdef CL_AXIL_CMD_MST_TIMEOUT_EN
    task automatic test_timeout;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        int t = 0;
        int b_rr = rrdy_cyc;
        r_never = 1;
        sb.push_back('{1'b0, 32'h0, 2'b10});
        send_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        while (bus.rsp_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        n_vec++;
        if (rrdy_cyc - b_rr !== 16) begin
            n_err++; $display("FAIL tmo_cycles: got %0d rready cycles want 16", rrdy_cyc - b_rr);
        end
        get_rsp(w, d, r, ok);
        e = sb.pop_front();
        n_vec++;
        if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
            n_err++; $display("FAIL tmo_rsp: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                              ok, w, d, r, e.write, e.rdata, e.resp);
        end
        r_late_tgl = ~r_late_tgl;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({timeout_err, bus.m_rready, bus.m_bready, bus.rsp_valid, busy} !== 5'b11100) begin
            n_err++; $display("FAIL tmo_swallow: got te/rr/br/rv/busy=%b want 11100",
                              {timeout_err, bus.m_rready, bus.m_bready, bus.rsp_valid, busy});
        end
        r_never = 0; rdata_cfg = 32'h7777_0001;
        sb.push_back('{1'b0, 32'h7777_0001, 2'b00});
        send_cmd(1'b0, 32'h0000_0034, 32'h0, 4'h0);
        get_rsp(w, d, r, ok);
        e = sb.pop_front();
        n_vec++;
        if (!ok || {w, d, r, timeout_err} !== {e.write, e.rdata, e.resp, 1'b1}) begin
            n_err++; $display("FAIL tmo_after: got ok=%0b w=%b d=%h r=%b te=%b want w=%b d=%h r=%b te=1",
                              ok, w, d, r, timeout_err, e.write, e.rdata, e.resp);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic w; logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        int b_aw;
        aw_delay = 20;
        send_cmd(1'b1, 32'h0000_3000, 32'h1111_2222, 4'hF);
        n_vec++;
        if ({bus.m_awvalid, busy} !== 2'b11) begin
            n_err++; $display("FAIL rstmid_pre: got aw/busy=%b want 11", {bus.m_awvalid, busy});
        end
        #2 rstn = 0;
        #1;
        n_vec++;
        if ({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, busy, bus.cmd_ready, bus.rsp_valid, timeout_err} !== 7'b0) begin
            n_err++; $display("FAIL rstmid_async: got aw/w/ar/busy/cr/rv/te=%b want 0000000",
                              {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, busy, bus.cmd_ready, bus.rsp_valid, timeout_err});
        end
        @(negedge clk);
        #1 rstn = 1;
        aw_delay = 0;
        b_aw = aw_beats;
        sb.push_back('{1'b1, 32'h0, 2'b00});
        send_cmd(1'b1, 32'h0000_3004, 32'h3333_4444, 4'hC);
        get_rsp(w, d, r, ok);
        e = sb.pop_front();
        n_vec++;
        if (!ok || {w, d, r} !== {e.write, e.rdata, e.resp}) begin
            n_err++; $display("FAIL rstmid_rsp: got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=%b",
                              ok, w, d, r, e.write, e.rdata, e.resp);
        end
        n_vec++;
        if ({aw_beats - b_aw, last_awaddr, last_wdata} !== {32'd1, 32'h0000_3004, 32'h3333_4444}) begin
            n_err++; $display("FAIL rstmid_payload: got aw=%0d a=%h d=%h want 1 00003004 33334444",
                              aw_beats - b_aw, last_awaddr, last_wdata);
        end
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 0;
        repeat (2) @(negedge clk);
        test_reset;
        test_write_basic;
        test_write_aw_delay;
        test_read;
        test_rsp_backpressure;
        test_back_to_back;
`ifdef CL_AXIL_CMD_MST_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cl_axil_cmd_mst.md
Name: cl_axil_cmd_mst

Overview:
- AXI4-Lite initiator that converts a single-beat command/response stream into AXI-Lite read and write transactions.
- Drives the same AXI-Lite register port that the shell's OCL/BAR1 path drives; it is the other end of that protocol.
- Allows on-fabric logic (debug sequencer, boot loader) to program NVDLA/cfgreg registers without the host.
- One transaction outstanding at a time.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- DATA_W, 32, data width; must be 32 (wstrb = DATA_W/8).
- TIMEOUT_CYCLES, 4096, response-wait limit; used only with the optional feature.

Ports:
- clk  in  1  main clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in/out  1 / 1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata / cmd_wstrb  in  DATA_W / DATA_W/8  write payload (ignored for reads)
- rsp_valid / rsp_ready  out/in  1 / 1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- m_awvalid, m_awready, m_awaddr  out, in, out  1, 1, ADDR_W
- m_wvalid, m_wready, m_wdata, m_wstrb  out, in, out, out  1, 1, DATA_W, DATA_W/8
- m_bvalid, m_bready, m_bresp  in, out, in  1, 1, 2
- m_arvalid, m_arready, m_araddr  out, in, out  1, 1, ADDR_W
- m_rvalid, m_rready, m_rdata, m_rresp  in, out, in, in  1, 1, DATA_W, 2
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky timeout flag (tied 0 when feature absent)

Behaviour:
- Reset (rstn low, async): state = IDLE. All valids = 0. cmd_ready = 0. rsp_* = 0. m_bready = m_rready = 0. busy = 0. Address/data registers cleared.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: register addr/wdata/wstrb/write.
  - Write → WR_REQ, with m_awvalid = m_wvalid = 1 on the next cycle. Read → RD_REQ, with m_arvalid = 1.
  - Command-accept to first valid: 1 cycle.
- WR_REQ:
  - AW and W are tracked independently by aw_done / w_done flags. Each valid drops the cycle after its own handshake.
  - When both are done (same or different cycles) → WR_RESP.
  - Valids are never deasserted before their handshake (AXI rule).
- WR_RESP: m_bready = 1. On m_bvalid: capture bresp, rdata = 0 → RSP.
- RD_REQ: hold m_arvalid until m_arready → RD_RESP.
- RD_RESP: m_rready = 1. On m_rvalid: capture rdata and rresp → RSP.
- RSP:
  - rsp_valid = 1; payload stable while rsp_ready is low.
  - On rsp_ready → IDLE. cmd_ready rises the following cycle, so back-to-back throughput is one command per (bus latency + 3) cycles minimum.
- B/R arriving while not in WR_RESP/RD_RESP cannot occur without a timeout (m_bready/m_rready are low). Address/data outputs stay stable while valid is high.
- Reset mid-transaction: abort immediately. Outstanding AXI state is the slave's responsibility (the slave shares the reset).
- Nonzero BRESP/RRESP is passed through unchanged. No retry.

Optional Feature:
- Macro: CL_AXIL_CMD_MST_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to WR_RESP/RD_RESP and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES-1 without bvalid/rvalid: go to RSP with rsp_resp = 2'b10 and rdata = 0, and set timeout_err (sticky until reset).
  - m_bready and m_rready are then held high in IDLE to swallow any late response, which is discarded.
  - Timeout never applies in WR_REQ/RD_REQ (valid cannot be withdrawn).
- Without the macro: wait indefinitely, timeout_err = 0, and m_bready/m_rready are asserted only in the RESP states.

Decomposition:
- Package cl_axil_mst_pkg: state enum, AXI response constants (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11), and a cmd struct {write, addr, wdata, wstrb}.
- One sub-module: cl_axil_mst_tmo, the timeout counter with clear/enable/expire. Instantiated only under the macro.

Test Plan:
- Write 0x0000_1000 ← 0xDEAD_BEEF, strb 0xF, slave accepts AW and W in the same cycle, BRESP = 0 → exactly one AW beat, one W beat, then rsp_valid with resp = 0, rdata = 0, rsp_write = 1.
- Write with m_awready delayed 5 cycles and m_wready immediate → m_wvalid drops after 1 cycle; m_awvalid stays high with stable addr until accepted; single response.
- Read 0x0000_0004, slave returns 0x1234_5678 with RRESP = 2'b11 → rsp_rdata = 0x1234_5678, rsp_resp = 2'b11.
- rsp_ready held low for 10 cycles → rsp_valid and payload stable; no new cmd_ready until the response is accepted.
- With CL_AXIL_CMD_MST_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never asserts rvalid → response after 16 cycles in RD_RESP with resp = 2'b10; timeout_err = 1; a late rvalid is absorbed while in IDLE.
- rstn pulsed low in WR_REQ → all valids = 0 and busy = 0 asynchronously; the next command completes normally.
